d7seg_scan_ctrl: RTL and testbench
==================================

# d7seg_scan_ctrl

Parametrised multiplexed 7-segment display controller that drives N common-anode/cathode digits from a packed hex value. It replaces the direct 16-bit d7seg export with time-multiplexed scanning, tear-free double-buffered update, PWM brightness, leading-zero suppression and anti-ghosting dead time. It sits between the system-bus PIO export and the board segment/digit pins.

## Interface
- DIGITS, 4: number of digits scanned (1..8)
- CLK_HZ, 50_000_000: clk_clk frequency
- SCAN_HZ, 1000: digit-slot rate; TICK_DIV = CLK_HZ/SCAN_HZ cycles per slot
- PWM_BITS, 4: brightness resolution
- DEAD, 2: cycles at start of each slot with all digits off
- SEG_ACTIVE_LOW, 1: segment/dp pin polarity
- DIG_ACTIVE_LOW, 1: digit-select pin polarity

Ports:
- clk_clk  in  1  system clock
- reset_reset_n  in  1  asynchronous active-low reset
- enable  in  1  scan enable
- load  in  1  one-cycle strobe capturing value_in/dp_in into pending buffer
- value_in  in  4*DIGITS  nibble i = digit i (digit 0 least significant)
- dp_in  in  DIGITS  decimal point per digit
- lz_suppress  in  1  blank leading zero digits
- brightness  in  PWM_BITS  duty; 0 = off, all-ones = full on
- seg_out  out  7  {g,f,e,d,c,b,a}
- dp_out  out  1  decimal point pin
- dig_out  out  DIGITS  one-hot digit select
- frame_done  out  1  one-cycle pulse at frame boundary

## Operation
- Two buffers: pending (written on load) and active (drives display). active <= pending on frame boundary only; no mid-frame tearing.
- load coinciding with frame boundary: new value_in/dp_in goes straight into active (bypass).
- slot_cnt counts 0..TICK_DIV-1; on wrap, dig_idx advances 0→1→…→DIGITS-1→0. Wrap of dig_idx = frame boundary.
- Digit lit when: enable, slot_cnt ≥ DEAD, and (pwm_cnt < brightness or brightness all-ones). pwm_cnt is PWM_BITS-wide free-running, cleared at each slot start.
- Hex decode (active-high before polarity): 0:3F 1:06 2:5B 3:4F 4:66 5:6D 6:7D 7:07 8:7F 9:6F A:77 b:7C C:39 d:5E E:79 F:71.
- Leading-zero suppression: digit i (i>0) segments off when its nibble and all higher nibbles are 0; digit 0 never suppressed; dp still honoured.
- Polarity parameters invert seg_out/dp_out and dig_out at the pins only.
- enable low: slot_cnt, pwm_cnt, dig_idx cleared; outputs inactive; buffers and load still work. On re-enable, scan restarts at digit 0, slot 0.

## Timing
- Reset: seg_out, dp_out, dig_out at inactive level; frame_done 0; counters, dig_idx, pending, active = 0.
- All outputs registered; 1-cycle latency from counter state to pins.
- frame_done high exactly one cycle, on the cycle dig_idx wraps DIGITS-1→0 (same cycle active updates).
- Frame period = DIGITS*TICK_DIV cycles.
- Elaboration error if TICK_DIV < 2^PWM_BITS or DEAD ≥ TICK_DIV.
- Reset asserted mid-frame: all state returns to reset values immediately (asynchronous); scan resumes at digit 0.
- brightness/lz_suppress sampled live each cycle (no buffering).

## Structure
- Package d7seg_pkg: SEG_W = 7, hex-to-segment constant table, seg polarity helper function.
- Sub-module d7seg_hex_decode (combinational nibble→7-seg); rest (counters, buffers, PWM, output regs) in top.

## Test plan
Bench: CLK_HZ=3200, SCAN_HZ=100 (TICK_DIV=32), DIGITS=4, PWM_BITS=4, DEAD=2, both polarities low.
- Reset release, enable=1, load 0x12AF, brightness=F -> after first frame_done, slots show F(71), A(77), 2(5B), 1(06) on digits 0..3; dig_out low cycles 2..31 of each slot.
- load 0x0000→0x9999 mid-frame -> displayed value changes only after next frame_done; bypass: load on boundary cycle -> active = new value that same cycle.
- lz_suppress=1, value 0x0050 -> digits 3,2 blank (seg_out=7F), digit 1 shows 5, digit 0 shows 0; dp_in=4'b1000 -> dp_out low in digit 3 slot.
- brightness=4 -> digit lit exactly 4 of each 16 PWM cycles after dead time; brightness=0 -> dig_out all-high always.
- enable dropped mid-slot -> next cycle dig_out=4'hF, frame_done 0; re-enable -> digit 0 slot restarts, first frame_done after 128 cycles.
- Async reset pulse mid-frame -> outputs inactive without clock edge; active/pending cleared, display shows 0000 after reload.

Source files
------------

// File: rtl/d7seg_pkg.sv
// Shared definitions for the multiplexed 7-segment scan controller.
// Latency: n/a (types, constants and pure functions only).
// Backpressure: n/a.
//
// Contents:
//   SEG_W      - segment bus width, bit order {g,f,e,d,c,b,a}
//   DIGITS_MAX - largest digit count the scanner supports
//   HEX_SEG    - nibble -> active-high segment pattern table
//   seg_pol    - maps an active-high segment pattern onto pin polarity
package d7seg_pkg;

    localparam int SEG_W      = 7;
    localparam int DIGITS_MAX = 8;

    // Active-high patterns, index = nibble value. Lower-case b/d keep
    // 0xB/0xD distinguishable from 8/0 on a 7-segment face.
    localparam logic [SEG_W-1:0] HEX_SEG [16] = '{
        7'h3F,  // 0
        7'h06,  // 1
        7'h5B,  // 2
        7'h4F,  // 3
        7'h66,  // 4
        7'h6D,  // 5
        7'h7D,  // 6
        7'h07,  // 7
        7'h7F,  // 8
        7'h6F,  // 9
        7'h77,  // A
        7'h7C,  // b
        7'h39,  // C
        7'h5E,  // d
        7'h79,  // E
        7'h71   // F
    };

    // Polarity is applied once, right before the pin registers, so all
    // internal logic can stay active-high.
    function automatic logic [SEG_W-1:0] seg_pol(
        input logic [SEG_W-1:0] seg,
        input bit               active_low
    );
        return active_low ? ~seg : seg;
    endfunction

endpackage : d7seg_pkg

// File: rtl/d7seg_hex_decode.sv
// Nibble to 7-segment pattern decoder (active-high, before pin polarity).
// Latency: combinational, zero cycles.
// Backpressure: none; pure function of its input.
//
// Ports:
//   nibble_i - hex digit value 0..F
//   seg_o    - segment pattern {g,f,e,d,c,b,a}, 1 = segment lit
module d7seg_hex_decode
    import d7seg_pkg::*;
(
    input  logic [3:0]       nibble_i,
    output logic [SEG_W-1:0] seg_o
);

    assign seg_o = HEX_SEG[nibble_i];

endmodule : d7seg_hex_decode

// File: rtl/d7seg_scan_ctrl.sv
// Time-multiplexed N-digit 7-segment driver with double-buffered value, PWM dimming,
// Latency: one cycle from internal counter state to every pin (all outputs registered).
// Backpressure: none; load is a fire-and-forget strobe, the scan free-runs while enabled.
//
// Ports:
//   clk_clk        - system clock
//   reset_reset_n  - asynchronous active-low reset
//   enable         - scan enable; low clears the scan position and blanks the pins
//   load           - one-cycle strobe capturing value_in/dp_in into the pending buffer
//   value_in       - packed hex value, nibble i drives digit i (digit 0 = LSN)
//   dp_in          - decimal point per digit
//   lz_suppress    - blank leading zero digits (live, not buffered)
//   brightness     - PWM duty, 0 = off, all-ones = full on (live, not buffered)
//   seg_out        - segment pins {g,f,e,d,c,b,a}
//   dp_out         - decimal point pin
//   dig_out        - one-hot digit select pins
//   frame_done     - one-cycle pulse when the scan wraps back to digit 0
module d7seg_scan_ctrl
    import d7seg_pkg::*;
#(
    parameter int DIGITS         = 4,
    parameter int CLK_HZ         = 50_000_000,
    parameter int SCAN_HZ        = 1000,
    parameter int PWM_BITS       = 4,
    parameter int DEAD           = 2,
    parameter bit SEG_ACTIVE_LOW = 1'b1,
    parameter bit DIG_ACTIVE_LOW = 1'b1
) (
    input  logic                  clk_clk,
    input  logic                  reset_reset_n,
    input  logic                  enable,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   value_in,
    input  logic [DIGITS-1:0]     dp_in,
    input  logic                  lz_suppress,
    input  logic [PWM_BITS-1:0]   brightness,
    output logic [SEG_W-1:0]      seg_out,
    output logic                  dp_out,
    output logic [DIGITS-1:0]     dig_out,
    output logic                  frame_done
);

    localparam int TICK_DIV = CLK_HZ / SCAN_HZ;
    localparam int CNT_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int IDX_W    = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int VAL_W    = 4 * DIGITS;

    localparam logic [CNT_W-1:0] SLOT_LAST = CNT_W'(TICK_DIV - 1);
    localparam logic [CNT_W-1:0] DEAD_C    = CNT_W'(DEAD);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(DIGITS - 1);

    // Pin levels while nothing is being driven.
    localparam logic [SEG_W-1:0]  SEG_IDLE = seg_pol({SEG_W{1'b0}}, SEG_ACTIVE_LOW);
    localparam logic              DP_IDLE  = SEG_ACTIVE_LOW;
    localparam logic [DIGITS-1:0] DIG_IDLE = {DIGITS{DIG_ACTIVE_LOW}};

    // ------------------------------------------------------------------
    // Elaboration-time parameter sanity
    // ------------------------------------------------------------------
    if (DIGITS < 1 || DIGITS > DIGITS_MAX) begin : g_bad_digits
        $error("d7seg_scan_ctrl: DIGITS must be 1..%0d", DIGITS_MAX);
    end
    // A slot must hold at least one full PWM period or the duty cycle is
    // truncated at the slot boundary.
    if (TICK_DIV < (1 << PWM_BITS)) begin : g_bad_tick
        $error("d7seg_scan_ctrl: TICK_DIV (%0d) shorter than PWM period", TICK_DIV);
    end
    if (DEAD >= TICK_DIV) begin : g_bad_dead
        $error("d7seg_scan_ctrl: DEAD (%0d) must be below TICK_DIV (%0d)", DEAD, TICK_DIV);
    end

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [CNT_W-1:0]    slot_cnt_q, slot_cnt_d;
    logic [PWM_BITS-1:0] pwm_cnt_q,  pwm_cnt_d;
    logic [IDX_W-1:0]    dig_idx_q,  dig_idx_d;

    logic [VAL_W-1:0]    pend_val_q, pend_val_d;
    logic [DIGITS-1:0]   pend_dp_q,  pend_dp_d;
    logic [VAL_W-1:0]    act_val_q,  act_val_d;
    logic [DIGITS-1:0]   act_dp_q,   act_dp_d;

    logic [SEG_W-1:0]    seg_out_q,    seg_out_d;
    logic                dp_out_q,     dp_out_d;
    logic [DIGITS-1:0]   dig_out_q,    dig_out_d;
    logic                frame_done_q, frame_done_d;

    // ------------------------------------------------------------------
    // Scan counters
    // ------------------------------------------------------------------
    logic slot_wrap;
    logic frame_wrap;

    assign slot_wrap  = enable && (slot_cnt_q == SLOT_LAST);
    assign frame_wrap = slot_wrap && (dig_idx_q == IDX_LAST);

    always_comb begin
        slot_cnt_d = '0;
        pwm_cnt_d  = '0;
        dig_idx_d  = '0;
        // Disabled: everything parks at zero so re-enable starts a clean
        // frame at digit 0, slot 0.
        if (enable) begin
            if (slot_wrap) begin
                slot_cnt_d = '0;
                pwm_cnt_d  = '0;
                dig_idx_d  = frame_wrap ? '0 : dig_idx_q + IDX_W'(1);
            end else begin
                slot_cnt_d = slot_cnt_q + CNT_W'(1);
                pwm_cnt_d  = pwm_cnt_q + PWM_BITS'(1);
                dig_idx_d  = dig_idx_q;
            end
        end
    end

    // ------------------------------------------------------------------
    // Double buffer: pending follows load, active only moves at the frame
    // boundary so a frame never shows a mix of old and new digits.
    // ------------------------------------------------------------------
    always_comb begin
        pend_val_d = load ? value_in : pend_val_q;
        pend_dp_d  = load ? dp_in    : pend_dp_q;

        act_val_d  = act_val_q;
        act_dp_d   = act_dp_q;
        if (frame_wrap) begin
            // A load landing exactly on the boundary goes straight to active;
            // otherwise it would sit in pending for a whole extra frame.
            act_val_d = load ? value_in : pend_val_q;
            act_dp_d  = load ? dp_in    : pend_dp_q;
        end
    end

    // ------------------------------------------------------------------
    // Current digit selection
    // ------------------------------------------------------------------
    logic [3:0]        cur_nib;
    logic              cur_dp;
    logic [DIGITS-1:0] cur_onehot;

    always_comb begin
        cur_nib    = '0;
        cur_dp     = 1'b0;
        cur_onehot = '0;
        for (int i = 0; i < DIGITS; i++) begin
            if (dig_idx_q == IDX_W'(i)) begin
                cur_nib       = act_val_q[4*i +: 4];
                cur_dp        = act_dp_q[i];
                cur_onehot[i] = 1'b1;
            end
        end
    end

    // Leading-zero blanking: walk from the most significant digit down,
    // keeping a running "everything from here up is zero" flag. Digit 0 is
    // excluded so a zero value still shows a single 0.
    logic lz_blank;
    logic zero_run;

    always_comb begin
        lz_blank = 1'b0;
        zero_run = 1'b1;
        for (int i = DIGITS - 1; i >= 1; i--) begin
            zero_run = zero_run && (act_val_q[4*i +: 4] == 4'h0);
            if (dig_idx_q == IDX_W'(i)) begin
                lz_blank = zero_run;
            end
        end
        lz_blank = lz_blank && lz_suppress;
    end

    logic [SEG_W-1:0] dec_seg;

    d7seg_hex_decode u_hex_decode (
        .nibble_i (cur_nib),
        .seg_o    (dec_seg)
    );

    // ------------------------------------------------------------------
    // Drive qualification and pin encoding
    // ------------------------------------------------------------------
    logic             pwm_on;
    logic             lit;
    logic [SEG_W-1:0] seg_on;

    // All-ones brightness is forced on so full scale really means 100 %
    // rather than (2^PWM_BITS - 1) / 2^PWM_BITS.
    assign pwm_on = (pwm_cnt_q < brightness) || (&brightness);
    assign lit    = enable && (slot_cnt_q >= DEAD_C) && pwm_on;

    // Segments and dp are blanked together with the digit select, so the
    // dead window also keeps the previous digit's pattern off the next
    // digit while the driver transistors switch over.
    assign seg_on = (lit && !lz_blank) ? dec_seg : '0;

    always_comb begin
        seg_out_d    = seg_pol(seg_on, SEG_ACTIVE_LOW);
        dp_out_d     = (lit && cur_dp) ^ SEG_ACTIVE_LOW;
        dig_out_d    = (lit ? cur_onehot : '0) ^ DIG_IDLE;
        frame_done_d = frame_wrap;
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            slot_cnt_q   <= '0;
            pwm_cnt_q    <= '0;
            dig_idx_q    <= '0;
            pend_val_q   <= '0;
            pend_dp_q    <= '0;
            act_val_q    <= '0;
            act_dp_q     <= '0;
            seg_out_q    <= SEG_IDLE;
            dp_out_q     <= DP_IDLE;
            dig_out_q    <= DIG_IDLE;
            frame_done_q <= 1'b0;
        end else begin
            slot_cnt_q   <= slot_cnt_d;
            pwm_cnt_q    <= pwm_cnt_d;
            dig_idx_q    <= dig_idx_d;
            pend_val_q   <= pend_val_d;
            pend_dp_q    <= pend_dp_d;
            act_val_q    <= act_val_d;
            act_dp_q     <= act_dp_d;
            seg_out_q    <= seg_out_d;
            dp_out_q     <= dp_out_d;
            dig_out_q    <= dig_out_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign seg_out    = seg_out_q;
    assign dp_out     = dp_out_q;
    assign dig_out    = dig_out_q;
    assign frame_done = frame_done_q;

endmodule : d7seg_scan_ctrl

// File: tb/tb_d7seg_scan_ctrl.sv
// Directed bench for d7seg_scan_ctrl: 4 digits, 32-cycle slots, 4-bit PWM, DEAD=2, active-low pins.
// Latency: expected pin state for cycle k after a frame_done reflects slot (k-1) of the frame.
// Backpressure: n/a.
module tb_d7seg_scan_ctrl;

    logic        clk_clk = 1'b0;
    logic        reset_reset_n;
    logic        enable;
    logic        load;
    logic [15:0] value_in;
    logic [3:0]  dp_in;
    logic        lz_suppress;
    logic [3:0]  brightness;
    logic [6:0]  seg_out;
    logic        dp_out;
    logic [3:0]  dig_out;
    logic        frame_done;

    int n_checks = 0;
    int n_errors = 0;

    // Active-high patterns for 0..F, {g,f,e,d,c,b,a}.
    localparam logic [6:0] SEG_TAB [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

    always #5 clk_clk = ~clk_clk;

    d7seg_scan_ctrl #(
        .DIGITS         (4),
        .CLK_HZ         (3200),
        .SCAN_HZ        (100),
        .PWM_BITS       (4),
        .DEAD           (2),
        .SEG_ACTIVE_LOW (1'b1),
        .DIG_ACTIVE_LOW (1'b1)
    ) dut (
        .clk_clk       (clk_clk),
        .reset_reset_n (reset_reset_n),
        .enable        (enable),
        .load          (load),
        .value_in      (value_in),
        .dp_in         (dp_in),
        .lz_suppress   (lz_suppress),
        .brightness    (brightness),
        .seg_out       (seg_out),
        .dp_out        (dp_out),
        .dig_out       (dig_out),
        .frame_done    (frame_done)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Waits for frame_done on negedges; n = negedges waited.
    task automatic wait_fd(output int n);
        n = 0;
        while (n < 400) begin
            @(negedge clk_clk);
            n++;
            if (frame_done) break;
        end
        check("fd_seen", 32'(frame_done), 32'd1);
    endtask

    // Called on the negedge of a frame_done cycle. Checks every pin for the
    // 128 cycles of the following frame. Optionally pulses load for one
    // cycle, driven on the negedge of step ld_k (0 = before the first step).
    task automatic check_frame(input logic [15:0] val, input logic [3:0] dpv,
                               input logic [3:0] br, input bit lz, input int ld_k,
                               input logic [15:0] ld_val, input logic [3:0] ld_dp);
        int         d;
        int         s;
        bit         lit;
        bit         blank;
        logic [3:0] nib;
        logic [15:0] hi;
        logic [3:0] exp_dig;
        logic [6:0] exp_seg;
        logic       exp_dp;
        if (ld_k == 0) begin
            load     = 1'b1;
            value_in = ld_val;
            dp_in    = ld_dp;
        end
        for (int k = 1; k <= 128; k++) begin
            @(negedge clk_clk);
            d       = (k - 1) / 32;
            s       = (k - 1) % 32;
            lit     = (s >= 2) && ((br == 4'hF) || ((s % 16) < br));
            nib     = val[4*d +: 4];
            hi      = val >> (4 * d);
            blank   = lz && (d > 0) && (hi == 16'h0);
            exp_dig = lit ? ~(4'b0001 << d) : 4'hF;
            exp_seg = (lit && !blank) ? ~SEG_TAB[nib] : 7'h7F;
            exp_dp  = (lit && dpv[d]) ? 1'b0 : 1'b1;
            check($sformatf("dig v%h k%0d", val, k), 32'(dig_out), 32'(exp_dig));
            check($sformatf("seg v%h k%0d", val, k), 32'(seg_out), 32'(exp_seg));
            check($sformatf("dp v%h k%0d", val, k), 32'(dp_out), 32'(exp_dp));
            check($sformatf("fd v%h k%0d", val, k), 32'(frame_done), (k == 128) ? 32'd1 : 32'd0);
            load = 1'b0;
            if (k == ld_k) begin
                load     = 1'b1;
                value_in = ld_val;
                dp_in    = ld_dp;
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        reset_reset_n = 1'b0;
        enable        = 1'b0;
        load          = 1'b0;
        value_in      = 16'h0;
        dp_in         = 4'h0;
        lz_suppress   = 1'b0;
        brightness    = 4'hF;

        // Reset state
        repeat (3) @(negedge clk_clk);
        check("rst_seg", 32'(seg_out), 32'h7F);
        check("rst_dp", 32'(dp_out), 32'd1);
        check("rst_dig", 32'(dig_out), 32'hF);
        check("rst_fd", 32'(frame_done), 32'd0);

        // Release, enable and load 12AF into pending.
        reset_reset_n = 1'b1;
        enable        = 1'b1;
        load          = 1'b1;
        value_in      = 16'h12AF;
        @(negedge clk_clk);
        load = 1'b0;
        wait_fd(n);
        check("first_fd_cycles", 32'(n), 32'd127);

        // 12AF on screen; 0000 loaded at slot start must not appear until next frame.
        check_frame(16'h12AF, 4'h0, 4'hF, 1'b0, 0, 16'h0000, 4'h0);
        // 0000 on screen; 9999 loaded mid-frame.
        check_frame(16'h0000, 4'h0, 4'hF, 1'b0, 60, 16'h9999, 4'h0);
        // 9999 on screen; 0050 loaded on the boundary cycle bypasses pending.
        check_frame(16'h9999, 4'h0, 4'hF, 1'b0, 127, 16'h0050, 4'b1000);

        // Leading-zero suppression with dp on digit 3.
        lz_suppress = 1'b1;
        check_frame(16'h0050, 4'b1000, 4'hF, 1'b1, -1, 16'h0, 4'h0);

        // PWM duty 4/16, then fully off.
        brightness = 4'h4;
        check_frame(16'h0050, 4'b1000, 4'h4, 1'b1, -1, 16'h0, 4'h0);
        brightness = 4'h0;
        check_frame(16'h0050, 4'b1000, 4'h0, 1'b1, -1, 16'h0, 4'h0);

        // Enable dropped mid-slot (digit 1, slot 12).
        brightness = 4'hF;
        repeat (45) @(negedge clk_clk);
        check("pre_drop_dig", 32'(dig_out), 32'hD);
        enable = 1'b0;
        @(negedge clk_clk);
        check("drop_dig", 32'(dig_out), 32'hF);
        check("drop_seg", 32'(seg_out), 32'h7F);
        check("drop_dp", 32'(dp_out), 32'd1);
        check("drop_fd", 32'(frame_done), 32'd0);
        for (int i = 0; i < 140; i++) begin
            @(negedge clk_clk);
            check("off_dig", 32'(dig_out), 32'hF);
            check("off_fd", 32'(frame_done), 32'd0);
        end

        // Re-enable: digit 0 slot restarts, first frame_done 128 cycles later.
        enable = 1'b1;
        n = 0;
        while (n < 400) begin
            @(negedge clk_clk);
            n++;
            if (n == 2) check("reen_dead_dig", 32'(dig_out), 32'hF);
            if (n == 3) begin
                check("reen_lit_dig", 32'(dig_out), 32'hE);
                check("reen_lit_seg", 32'(seg_out), 32'h40);
            end
            if (frame_done) break;
        end
        check("reen_fd_cycles", 32'(n), 32'd128);

        // Async reset mid-frame (digit 1, slot 17), away from any clock edge.
        repeat (50) @(negedge clk_clk);
        check("pre_rst_dig", 32'(dig_out), 32'hD);
        #2;
        reset_reset_n = 1'b0;
        #1;
        check("arst_dig", 32'(dig_out), 32'hF);
        check("arst_seg", 32'(seg_out), 32'h7F);
        check("arst_dp", 32'(dp_out), 32'd1);
        check("arst_fd", 32'(frame_done), 32'd0);
        @(negedge clk_clk);
        @(negedge clk_clk);
        reset_reset_n = 1'b1;
        lz_suppress   = 1'b0;
        wait_fd(n);
        check("rst_fd_cycles", 32'(n), 32'd128);

        // Buffers were cleared: 0000 with no dp, then reload 0000 and show it again.
        check_frame(16'h0000, 4'h0, 4'hF, 1'b0, 10, 16'h0000, 4'h0);
        check_frame(16'h0000, 4'h0, 4'hF, 1'b0, -1, 16'h0, 4'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule : tb_d7seg_scan_ctrl
